// File: rtl/mbox_arbiter.sv
// mbox_arbiter: shared Z80/SPI mailbox store with a round-robin single-port arbiter and per-slot fresh flags
module mbox_arbiter #(
    parameter int SLOTS = 8,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               z80_req,
    input  logic               z80_we,
    input  logic [AW-1:0]      z80_addr,
    input  logic [7:0]         z80_wdata,
    output logic               z80_ack,
    output logic [7:0]         z80_rdata,
    input  logic               spi_req,
    input  logic               spi_we,
    input  logic [AW-1:0]      spi_addr,
    input  logic [7:0]         spi_wdata,
    output logic               spi_ack,
    output logic [7:0]         spi_rdata,
    output logic               z80_irq,
    output logic               spi_irq,
    output logic [SLOTS-1:0]   to_z80_fresh,
    output logic [SLOTS-1:0]   to_spi_fresh,
    output logic [8*SLOTS-1:0] mbox_flat
);
    logic [SLOTS-1:0][7:0] mem_q, mem_d;
    logic [SLOTS-1:0]      tz_q, tz_d, ts_q, ts_d;
    logic [7:0]            zrd_q, zrd_d, srd_q, srd_d;
    logic                  zack_q, zack_d, sack_q, sack_d;
    logic                  ptr_q, ptr_d;
    logic                  z_el, s_el, gz, gs;

    // ptr_q: 0 = Z80 wins the next tie, 1 = SPI wins the next tie
    always_comb begin
        z_el   = z80_req & ~zack_q;
        s_el   = spi_req & ~sack_q;
        gz     = z_el & (~s_el | ~ptr_q);
        gs     = s_el & ~gz;
        ptr_d  = (z_el & s_el) ? ~ptr_q : ptr_q;
        zack_d = gz;
        sack_d = gs;
        zrd_d  = (gz & ~z80_we) ? mem_q[z80_addr] : zrd_q;
        srd_d  = (gs & ~spi_we) ? mem_q[spi_addr] : srd_q;
        mem_d  = mem_q;
        tz_d   = tz_q;
        ts_d   = ts_q;
        if (gz & z80_we) begin
            mem_d[z80_addr] = z80_wdata;
            ts_d[z80_addr]  = 1'b1;
        end
        if (gz & ~z80_we) tz_d[z80_addr] = 1'b0;
        if (gs & spi_we) begin
            mem_d[spi_addr] = spi_wdata;
            tz_d[spi_addr]  = 1'b1;
        end
        if (gs & ~spi_we) ts_d[spi_addr] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q  <= '0;
            tz_q   <= '0;
            ts_q   <= '0;
            zrd_q  <= '0;
            srd_q  <= '0;
            zack_q <= 1'b0;
            sack_q <= 1'b0;
            ptr_q  <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            tz_q   <= tz_d;
            ts_q   <= ts_d;
            zrd_q  <= zrd_d;
            srd_q  <= srd_d;
            zack_q <= zack_d;
            sack_q <= sack_d;
            ptr_q  <= ptr_d;
        end
    end

    assign z80_ack      = zack_q;
    assign spi_ack      = sack_q;
    assign z80_rdata    = zrd_q;
    assign spi_rdata    = srd_q;
    assign to_z80_fresh = tz_q;
    assign to_spi_fresh = ts_q;
    assign z80_irq      = |tz_q;
    assign spi_irq      = |ts_q;
    assign mbox_flat    = mem_q;
endmodule

// File: tb/tb_mbox_arbiter.sv
// tb_mbox_arbiter: vector table, hand sequences and randomized traffic against a transaction-level mailbox model
module tb_mbox_arbiter;
    localparam int SLOTS = 8;
    localparam int AW    = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               z80_req, z80_we, spi_req, spi_we;
    logic [AW-1:0]      z80_addr, spi_addr;
    logic [7:0]         z80_wdata, spi_wdata, z80_rdata, spi_rdata;
    logic               z80_ack, spi_ack, z80_irq, spi_irq;
    logic [SLOTS-1:0]   to_z80_fresh, to_spi_fresh;
    logic [8*SLOTS-1:0] mbox_flat;

    int n_chk = 0;
    int n_fail = 0;

    mbox_arbiter #(.SLOTS(SLOTS), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .z80_req(z80_req), .z80_we(z80_we), .z80_addr(z80_addr), .z80_wdata(z80_wdata),
        .z80_ack(z80_ack), .z80_rdata(z80_rdata),
        .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
        .spi_ack(spi_ack), .spi_rdata(spi_rdata),
        .z80_irq(z80_irq), .spi_irq(spi_irq),
        .to_z80_fresh(to_z80_fresh), .to_spi_fresh(to_spi_fresh), .mbox_flat(mbox_flat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               r, zr, zw, sr, sw;
        logic [AW-1:0]      za, sa;
        logic [7:0]         zd, sd;
        logic               zack, sack;
        logic [7:0]         zrd, srd;
        logic [SLOTS-1:0]   tz, ts;
        logic [8*SLOTS-1:0] flat;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t v(input logic r, zr, zw, input logic [AW-1:0] za, input logic [7:0] zd,
                               input logic sr, sw, input logic [AW-1:0] sa, input logic [7:0] sd,
                               input logic zack, sack, input logic [7:0] zrd, srd,
                               input logic [SLOTS-1:0] tz, ts, input logic [8*SLOTS-1:0] flat);
        vec_t x;
        x.r = r; x.zr = zr; x.zw = zw; x.za = za; x.zd = zd;
        x.sr = sr; x.sw = sw; x.sa = sa; x.sd = sd;
        x.zack = zack; x.sack = sack; x.zrd = zrd; x.srd = srd;
        x.tz = tz; x.ts = ts; x.flat = flat;
        return x;
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic zack, sack, input logic [7:0] zrd, srd,
                             input logic [SLOTS-1:0] tz, ts, input logic [8*SLOTS-1:0] flat);
        check({tag, ".z80_ack"}, z80_ack, zack);
        check({tag, ".spi_ack"}, spi_ack, sack);
        check({tag, ".z80_rdata"}, z80_rdata, zrd);
        check({tag, ".spi_rdata"}, spi_rdata, srd);
        check({tag, ".to_z80_fresh"}, to_z80_fresh, tz);
        check({tag, ".to_spi_fresh"}, to_spi_fresh, ts);
        check({tag, ".z80_irq"}, z80_irq, |tz);
        check({tag, ".spi_irq"}, spi_irq, |ts);
        check({tag, ".mbox_flat"}, mbox_flat, flat);
    endtask

    task automatic drive(input logic r, zr, zw, input logic [AW-1:0] za, input logic [7:0] zd,
                         input logic sr, sw, input logic [AW-1:0] sa, input logic [7:0] sd);
        rst = r; z80_req = zr; z80_we = zw; z80_addr = za; z80_wdata = zd;
        spi_req = sr; spi_we = sw; spi_addr = sa; spi_wdata = sd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: byte array, fresh sets, and "who had the last tie"
    logic [7:0]       m_mem[SLOTS];
    logic [SLOTS-1:0] m_tz, m_ts;
    logic             m_zack, m_sack, m_tie_z;
    logic [7:0]       m_zrd, m_srd;

    function automatic logic [8*SLOTS-1:0] m_flat();
        logic [8*SLOTS-1:0] f = '0;
        for (int k = 0; k < SLOTS; k++) f[8*k +: 8] = m_mem[k];
        return f;
    endfunction

    task automatic model_cycle();
        logic ze, se, gz, gs;
        if (rst) begin
            for (int k = 0; k < SLOTS; k++) m_mem[k] = 8'h00;
            m_tz = '0; m_ts = '0; m_zack = 0; m_sack = 0;
            m_zrd = 8'h00; m_srd = 8'h00; m_tie_z = 1;
        end else begin
            ze = z80_req && !m_zack;
            se = spi_req && !m_sack;
            gz = ze && (!se || m_tie_z);
            gs = se && !gz;
            if (ze && se) m_tie_z = gs;
            if (gz && z80_we) begin m_mem[z80_addr] = z80_wdata; m_ts[z80_addr] = 1; end
            if (gz && !z80_we) begin m_zrd = m_mem[z80_addr]; m_tz[z80_addr] = 0; end
            if (gs && spi_we) begin m_mem[spi_addr] = spi_wdata; m_tz[spi_addr] = 1; end
            if (gs && !spi_we) begin m_srd = m_mem[spi_addr]; m_ts[spi_addr] = 0; end
            m_zack = gz;
            m_sack = gs;
        end
    endtask

    initial begin
        tbl[0]  = v(0, 1,1,3,8'hA5, 0,0,0,8'h00, 1,0,8'h00,8'h00, 8'h00,8'h08, 64'h00000000A5000000);
        tbl[1]  = v(0, 0,0,0,8'h00, 1,0,3,8'h00, 0,1,8'h00,8'hA5, 8'h00,8'h00, 64'h00000000A5000000);
        tbl[2]  = v(0, 0,0,0,8'h00, 0,0,0,8'h00, 0,0,8'h00,8'hA5, 8'h00,8'h00, 64'h00000000A5000000);
        tbl[3]  = v(1, 0,0,0,8'h00, 0,0,0,8'h00, 0,0,8'h00,8'h00, 8'h00,8'h00, 64'h0);
        tbl[4]  = v(0, 1,1,0,8'h11, 1,0,0,8'h00, 1,0,8'h00,8'h00, 8'h00,8'h01, 64'h11);
        tbl[5]  = v(0, 0,0,0,8'h00, 1,0,0,8'h00, 0,1,8'h00,8'h11, 8'h00,8'h00, 64'h11);
        tbl[6]  = v(0, 0,0,0,8'h00, 0,0,0,8'h00, 0,0,8'h00,8'h11, 8'h00,8'h00, 64'h11);
        tbl[7]  = v(0, 0,0,0,8'h00, 1,1,1,8'h22, 0,1,8'h00,8'h11, 8'h02,8'h00, 64'h2211);
        tbl[8]  = v(0, 0,0,0,8'h00, 1,1,5,8'h66, 0,0,8'h00,8'h11, 8'h02,8'h00, 64'h2211);
        tbl[9]  = v(0, 0,0,0,8'h00, 1,1,5,8'h66, 0,1,8'h00,8'h11, 8'h22,8'h00, 64'h0000660000002211);
        tbl[10] = v(0, 1,0,1,8'h00, 0,0,0,8'h00, 1,0,8'h22,8'h11, 8'h20,8'h00, 64'h0000660000002211);
        tbl[11] = v(0, 0,0,0,8'h00, 0,0,0,8'h00, 0,0,8'h22,8'h11, 8'h20,8'h00, 64'h0000660000002211);
        tbl[12] = v(0, 1,0,5,8'h00, 0,0,0,8'h00, 1,0,8'h66,8'h11, 8'h00,8'h00, 64'h0000660000002211);
        tbl[13] = v(0, 0,0,0,8'h00, 0,0,0,8'h00, 0,0,8'h66,8'h11, 8'h00,8'h00, 64'h0000660000002211);

        drive(1, 0,0,0,0, 0,0,0,0);
        tick();
        tick();
        check_all("reset", 0, 0, 8'h00, 8'h00, '0, '0, '0);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].r, tbl[i].zr, tbl[i].zw, tbl[i].za, tbl[i].zd,
                  tbl[i].sr, tbl[i].sw, tbl[i].sa, tbl[i].sd);
            tick();
            check_all($sformatf("vec%0d", i), tbl[i].zack, tbl[i].sack, tbl[i].zrd, tbl[i].srd,
                      tbl[i].tz, tbl[i].ts, tbl[i].flat);
        end

        // Continuous contention: acks must alternate starting with Z80
        drive(1, 0,0,0,0, 0,0,0,0);
        tick();
        for (int k = 0; k < 8; k++) begin
            drive(0, 1,0,2,0, 1,0,4,0);
            tick();
            check($sformatf("alt%0d.z80_ack", k), z80_ack, (k % 2) == 0);
            check($sformatf("alt%0d.spi_ack", k), spi_ack, (k % 2) == 1);
        end

        // Reset landing on a grant edge drops the request; held req is then served
        drive(0, 0,0,0,0, 0,0,0,0);
        tick();
        drive(1, 1,1,2,8'h77, 0,0,0,0);
        tick();
        check_all("rstgrant", 0, 0, 8'h00, 8'h00, '0, '0, '0);
        drive(0, 1,1,2,8'h77, 0,0,0,0);
        tick();
        check_all("rstretry", 1, 0, 8'h00, 8'h00, '0, 8'h04, 64'h770000);

        // Randomized traffic against the model
        drive(1, 0,0,0,0, 0,0,0,0);
        model_cycle();
        tick();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            if (z80_req && !m_zack) begin
                if ($urandom_range(0, 7) == 0) begin
                    z80_addr = AW'($urandom_range(0, SLOTS-1));
                    z80_wdata = 8'($urandom);
                end
            end else begin
                z80_req = 1'($urandom_range(0, 1));
                z80_we = 1'($urandom_range(0, 1));
                z80_addr = AW'($urandom_range(0, SLOTS-1));
                z80_wdata = 8'($urandom);
            end
            if (spi_req && !m_sack) begin
                if ($urandom_range(0, 7) == 0) begin
                    spi_addr = AW'($urandom_range(0, SLOTS-1));
                    spi_wdata = 8'($urandom);
                end
            end else begin
                spi_req = 1'($urandom_range(0, 1));
                spi_we = 1'($urandom_range(0, 1));
                spi_addr = AW'($urandom_range(0, SLOTS-1));
                spi_wdata = 8'($urandom);
            end
            model_cycle();
            tick();
            check_all($sformatf("rnd%0d", c), m_zack, m_sack, m_zrd, m_srd, m_tz, m_ts, m_flat());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mbox_arbiter.md
Name: mbox_arbiter

Overview:
- Owns the shared mailbox byte store between the Z80 bus-decode side and the SPI slave side.
- Arbitrates single-cycle read/write requests from the two requesters onto one storage port.
- Uses round-robin priority on ties.
- Tracks per-slot "fresh" flags in each direction and raises a level notification to the side that has unread data.
- Exports the full store as a flat vector for debug/legacy consumers.

Parameters:
- SLOTS, 8, number of byte slots (power of two, 2..16).
- AW, 3, slot address width, must equal log2(SLOTS).

Ports:
- clk  in  1  system clock (internal HF oscillator domain)
- rst  in  1  synchronous reset, active-high
- z80_req  in  1  Z80-side access request, held until z80_ack
- z80_we  in  1  1=write, 0=read; stable while z80_req high
- z80_addr  in  AW  slot index
- z80_wdata  in  8  write data
- z80_ack  out  1  one-cycle completion pulse
- z80_rdata  out  8  read data, valid when z80_ack=1
- spi_req  in  1  SPI-side request, same rules as z80_req
- spi_we  in  1  1=write, 0=read
- spi_addr  in  AW  slot index
- spi_wdata  in  8  write data
- spi_ack  out  1  one-cycle completion pulse
- spi_rdata  out  8  read data, valid when spi_ack=1
- z80_irq  out  1  OR of to_z80 fresh flags
- spi_irq  out  1  OR of to_spi fresh flags
- to_z80_fresh  out  SLOTS  per-slot: written by SPI, not yet read by Z80
- to_spi_fresh  out  SLOTS  per-slot: written by Z80, not yet read by SPI
- mbox_flat  out  8*SLOTS  store contents, slot i at bits [8i+7:8i]

Behaviour:
- Reset (rst=1 at a clk edge): all slots=0x00, both fresh vectors=0, both acks=0, both rdata=0x00, priority pointer=Z80. Takes effect on the same edge regardless of in-flight requests; a request pending at reset gets no ack and must be re-presented (req still high after reset counts as a new request).
- Eligibility in cycle N: requester X is eligible if X_req=1 and X_ack=0 in cycle N. A requester is never granted in its own ack cycle.
- Grant in cycle N:
  - one eligible requester → it wins;
  - both eligible → the pointer side wins, then the pointer flips to the loser;
  - a single-contender grant leaves the pointer unchanged;
  - neither eligible → idle.
- Storage update at the edge closing cycle N, granted write: store[addr] ← wdata.
- Ack timing: X_ack=1 during cycle N+1 only. For a read, X_rdata=store[addr] as sampled in cycle N, including writes committed at the edge closing N−1. X_rdata holds its value until the next read ack for that side.
- Throughput: one access per cycle total; each requester at most one per 2 cycles; with both requesters contending, grants alternate and there is no starvation.
- Fresh flags, updated at the grant edge:
  - SPI write slot i → to_z80_fresh[i]=1
  - Z80 write slot i → to_spi_fresh[i]=1
  - Z80 read slot i → to_z80_fresh[i]=0
  - SPI read slot i → to_spi_fresh[i]=0
  - Writes never clear a flag; reads never set one. Rewriting a fresh slot keeps the flag at 1.
- z80_irq / spi_irq: combinational OR of the registered fresh vectors, so they rise in the ack cycle of the setting write.
- mbox_flat: driven directly from the storage registers; reflects a write in cycle N+1.
- Addresses ≥ SLOTS are impossible by width; no error path is needed.
- Request fields changing while req=1 and not yet granted: the values sampled in the grant cycle are used.

Test Plan:
- After reset: Z80 write slot 3 = 0xA5 → z80_ack one cycle later; mbox_flat[31:24]=0xA5; to_spi_fresh=0x08; spi_irq=1; z80_irq=0.
- SPI read slot 3 after the previous step → spi_ack with spi_rdata=0xA5; to_spi_fresh=0x00; spi_irq=0 in the ack cycle.
- Both requests asserted in the same cycle (Z80 write slot 0=0x11, SPI read slot 0) after reset:
  - Z80 granted first, z80_ack in cycle+1;
  - SPI granted in cycle+1, spi_ack in cycle+2 with spi_rdata=0x11.
- Both requesters hold req continuously for 8 cycles → acks strictly alternate Z80, SPI, Z80, …; no side waits more than 1 cycle after eligibility.
- SPI writes slots 1 and 5 (0x22, 0x66) → to_z80_fresh=0x22, z80_irq=1. Z80 reads slot 1 → to_z80_fresh=0x20, z80_irq still 1. Z80 reads slot 5 → z80_irq=0.
- Z80 write request presented, rst pulsed in the grant cycle → no ack, slot unchanged 0x00, all flags 0. Request still high after reset is granted 1 cycle later with normal ack.
